fetch_unit: RTL and testbench

Instruction fetch stage for the out-of-order LC-3b core. Holds the architectural fetch PC, reads 16-bit instructions from the I-cache through a single-outstanding-request handshake, and buffers them in a small FIFO instruction queue. The issue stage sees the queue head as `instr`/`curr_pc`/`instr_is_new`. The block obeys issue-stage stall and branch redirects, and ROB flushes.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the I-cache request port and the issue-stage port of the fetch unit.
// master = fetch unit side, slave = I-cache / issue side.
interface fetch_unit_if;
  // Handshakes:
  // - I-cache: icache_read is a request that stays high, with icache_address
  //   unchanged, until the cycle in which icache_resp strobes for one cycle.
  //   icache_rdata is only meaningful in that cycle.
  // - Issue: instr_is_new acts as valid and ~stall acts as ready. The head is
  //   consumed in every cycle where both are high.
  logic        icache_read;
  logic [15:0] icache_address;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic [15:0] instr;
  logic [15:0] curr_pc;
  logic        instr_is_new;
  logic        stall;
  logic        pcmux_sel;
  logic [15:0] br_pc;
  logic        flush;
  logic [15:0] flush_pc;

  modport master (
    output icache_read, icache_address, instr, curr_pc, instr_is_new,
    input  icache_resp, icache_rdata, stall, pcmux_sel, br_pc, flush, flush_pc
  );

  modport slave (
    input  icache_read, icache_address, instr, curr_pc, instr_is_new,
    output icache_resp, icache_rdata, stall, pcmux_sel, br_pc, flush, flush_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding I-cache request and a
// small FIFO of {instr, pc+2} entries presented to the issue stage.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     stale_addr_q, stale_addr_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     q_instr_q [DEPTH];
  logic [15:0]     q_instr_d [DEPTH];
  logic [15:0]     q_pc_q    [DEPTH];
  logic [15:0]     q_pc_d    [DEPTH];

  logic            req;
  logic [15:0]     req_addr;
  logic            not_empty;
  logic            deq;
  logic            redir;
  logic            kill;
  logic            enq;
  logic [15:0]     pc_plus2;

  // Request outputs depend only on state, count, fetch_pc and stale_addr.
  always_comb begin
    req      = 1'b0;
    req_addr = fetch_pc_q;
    case (state_q)
      ST_FETCH: req = (count_q < DEPTH_C);
      ST_DRAIN: begin
        req      = 1'b1;
        req_addr = stale_addr_q;
      end
      default: req = 1'b0;
    endcase
  end

  assign bus.icache_read    = req;
  assign bus.icache_address = req_addr;

  assign not_empty = (count_q != '0);
  assign deq       = not_empty & ~bus.stall;
  assign redir     = deq & bus.pcmux_sel;
  assign kill      = bus.flush | redir;
  assign enq       = (state_q == ST_FETCH) & req & bus.icache_resp & ~kill;
  assign pc_plus2  = fetch_pc_q + 16'd2;

  assign bus.instr_is_new = not_empty;
  assign bus.instr        = not_empty ? q_instr_q[head_q] : 16'h0000;
  assign bus.curr_pc      = not_empty ? q_pc_q[head_q]    : 16'h0000;
  assign dbg_state        = state_q;

  // Control next-state: a kill with a request in flight must wait out the
  // stale response in DRAIN so it is never mistaken for the new stream.
  always_comb begin
    state_d      = state_q;
    stale_addr_d = stale_addr_q;
    fetch_pc_d   = fetch_pc_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (kill && req && !bus.icache_resp) begin
          state_d      = ST_DRAIN;
          stale_addr_d = fetch_pc_q;
        end
      end
      ST_DRAIN: begin
        if (bus.icache_resp) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush)  fetch_pc_d = bus.flush_pc;
    else if (redir) fetch_pc_d = bus.br_pc;
    else if (enq)   fetch_pc_d = pc_plus2;
  end

  // Queue next-state.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        q_instr_d[tail_q] = bus.icache_rdata;
        q_pc_d[tail_q]    = pc_plus2;
        tail_d            = tail_q + PW'(1);
      end
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      q_instr_q    <= q_instr_d;
      q_pc_q       <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (expected next PC per dequeue).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  bit          inject_stale = 1'b0;
  int          hold_n = 0;
  int          hold_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;
  int          n_deq;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // I-cache model: answers a request after cur_lat cycles, data = mem_f(addr).
  int          wait_cnt = 0;
  int          cur_lat = 1;
  logic [15:0] req_addr = 16'h0000;
  always @(negedge clk) begin : cache_model
    bus.icache_resp = 1'b0;
    if (!reset_n) wait_cnt = 0;
    if (inject_stale) begin
      bus.icache_resp  = 1'b1;
      bus.icache_rdata = 16'hDEAD;
    end else if (reset_n && bus.icache_read) begin
      if (wait_cnt == 0) begin
        req_addr = bus.icache_address;
        cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end
      if (wait_cnt >= cur_lat) begin
        hold_n++;
        if (bus.icache_address !== req_addr) hold_bad++;
        bus.icache_resp  = 1'b1;
        bus.icache_rdata = mem_f(bus.icache_address);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stall     = 1'b1;
    bus.pcmux_sel = 1'b0;
    bus.br_pc     = 16'h0000;
    bus.flush     = 1'b0;
    bus.flush_pc  = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"},  16'(bus.icache_read), 16'd0);
    chk({tag, "_addr"},  bus.icache_address, 16'h0000);
    chk({tag, "_new"},   16'(bus.instr_is_new), 16'd0);
    chk({tag, "_instr"}, bus.instr, 16'h0000);
    chk({tag, "_pc"},    bus.curr_pc, 16'h0000);
  endtask

  // Ends on the negedge where reset_n is released (cycle 0).
  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    lat      = 1;
    lat_rand = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios + scoreboard ----------------
  initial begin
    idle_inputs();
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = 16'h0000;

    // Reset fetch: first request in cycle 1, data visible the cycle after resp.
    do_reset();
    cyc(1);
    chk("t1_read", 16'(bus.icache_read), 16'd1);
    chk("t1_addr", bus.icache_address, 16'h0000);
    cyc(1);
    chk("t1_new_early", 16'(bus.instr_is_new), 16'd0);
    cyc(1);
    chk("t1_new", 16'(bus.instr_is_new), 16'd1);
    chk("t1_instr", bus.instr, 16'h1234);
    chk("t1_pc", bus.curr_pc, 16'h0002);

    // Fill and back-pressure.
    cyc(9);
    chk("t2_full_read", 16'(bus.icache_read), 16'd0);
    chk("t2_full_new", 16'(bus.instr_is_new), 16'd1);
    exp_q = {16'h0002, 16'h0004, 16'h0006, 16'h0008};
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      if (i > 0) cyc(1);
      e = exp_q.pop_front();
      chk("t2_order_pc", bus.curr_pc, e);
      chk("t2_order_instr", bus.instr, mem_f(e - 16'd2));
    end
    bus.stall = 1'b1;

    // Redirect: ignored under stall, honoured without it.
    do_reset();
    cyc(12);
    chk("t3_full_read", 16'(bus.icache_read), 16'd0);
    bus.pcmux_sel = 1'b1;
    bus.br_pc     = 16'h0100;
    cyc(1);
    chk("t3_stall_new", 16'(bus.instr_is_new), 16'd1);
    chk("t3_stall_pc", bus.curr_pc, 16'h0002);
    chk("t3_stall_addr", bus.icache_address, 16'h0008);
    bus.stall = 1'b0;
    cyc(1);
    idle_inputs();
    chk("t3_redir_new", 16'(bus.instr_is_new), 16'd0);
    chk("t3_redir_read", 16'(bus.icache_read), 16'd1);
    chk("t3_redir_addr", bus.icache_address, 16'h0100);
    cyc(2);
    chk("t3_target_pc", bus.curr_pc, 16'h0102);
    chk("t3_target_instr", bus.instr, mem_f(16'h0100));

    // Drain: slow request to 0x0006 outlives a flush to 0x0200.
    do_reset();
    cyc(7);
    chk("t4_req_addr", bus.icache_address, 16'h0006);
    lat = 3;
    cyc(1);
    bus.flush    = 1'b1;
    bus.flush_pc = 16'h0200;
    cyc(1);
    bus.flush = 1'b0;
    chk("t4_drain_read", 16'(bus.icache_read), 16'd1);
    chk("t4_drain_addr", bus.icache_address, 16'h0006);
    chk("t4_drain_new", 16'(bus.instr_is_new), 16'd0);
    cyc(1);
    chk("t4_drain_addr2", bus.icache_address, 16'h0006);
    cyc(1);
    chk("t4_after_addr", bus.icache_address, 16'h0200);
    chk("t4_after_new", 16'(bus.instr_is_new), 16'd0);
    lat = 1;
    cyc(4);
    chk("t4_target_pc", bus.curr_pc, 16'h0202);
    chk("t4_target_instr", bus.instr, mem_f(16'h0200));

    // Priority and coincidence: flush + redirect in the response cycle.
    do_reset();
    cyc(4);
    bus.stall     = 1'b0;
    bus.pcmux_sel = 1'b1;
    bus.br_pc     = 16'h0300;
    bus.flush     = 1'b1;
    bus.flush_pc  = 16'h0400;
    cyc(1);
    idle_inputs();
    chk("t5_new", 16'(bus.instr_is_new), 16'd0);
    chk("t5_read", 16'(bus.icache_read), 16'd1);
    chk("t5_addr", bus.icache_address, 16'h0400);
    cyc(2);
    chk("t5_target_pc", bus.curr_pc, 16'h0402);
    chk("t5_target_instr", bus.instr, mem_f(16'h0400));

    // Async reset mid-request, stale response in IDLE, PC wrap.
    do_reset();
    lat = 5;
    cyc(2);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    inject_stale = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    inject_stale = 1'b0;
    @(negedge clk);
    lat = 1;
    chk("t6_stale_new", 16'(bus.instr_is_new), 16'd0);
    chk("t6_read", 16'(bus.icache_read), 16'd1);
    chk("t6_addr", bus.icache_address, 16'h0000);
    bus.flush    = 1'b1;
    bus.flush_pc = 16'hFFFE;
    cyc(1);
    bus.flush = 1'b0;
    chk("t6_drain_addr", bus.icache_address, 16'h0000);
    cyc(1);
    chk("t6_wrap_req", bus.icache_address, 16'hFFFE);
    cyc(2);
    chk("t6_wrap_new", 16'(bus.instr_is_new), 16'd1);
    chk("t6_wrap_pc", bus.curr_pc, 16'h0000);
    chk("t6_wrap_instr", bus.instr, mem_f(16'hFFFE));
    chk("t6_wrap_next", bus.icache_address, 16'h0000);

    // Randomized run against the stream model.
    do_reset();
    lat_rand = 1'b1;
    exp_pc   = 16'h0000;
    n_deq    = 0;
    for (int c = 0; c < 3000; c++) begin
      logic d;
      @(negedge clk);
      bus.stall     = ($urandom_range(0, 99) < 35);
      bus.pcmux_sel = ($urandom_range(0, 99) < 10);
      bus.br_pc     = 16'($urandom) & 16'hFFFE;
      bus.flush     = ($urandom_range(0, 99) < 3);
      bus.flush_pc  = 16'($urandom) & 16'hFFFE;
      if (bus.instr_is_new) begin
        chk("rnd_pc", bus.curr_pc, exp_pc + 16'd2);
        chk("rnd_instr", bus.instr, mem_f(exp_pc));
      end else begin
        chk("rnd_empty_instr", bus.instr, 16'h0000);
        chk("rnd_empty_pc", bus.curr_pc, 16'h0000);
      end
      d = bus.instr_is_new && !bus.stall;
      if (d) n_deq++;
      if (bus.flush)                exp_pc = bus.flush_pc;
      else if (d && bus.pcmux_sel)  exp_pc = bus.br_pc;
      else if (d)                   exp_pc = exp_pc + 16'd2;
    end
    idle_inputs();
    lat_rand = 1'b0;
    chk("rnd_progress", 16'(n_deq > 200), 16'd1);
    cyc(2);
    chk("addr_hold_errors", 16'(hold_bad), 16'd0);
    chk("responses_seen", 16'(hold_n > 100), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
